// File: rtl/axi_lite_arbiter_2to1_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_arbiter_2to1_if
// Brief    : AXI4-lite channel bundle (AW, W, B, AR, R) without response codes.
// Revision : 1.0
// ============================================================================
interface axi_lite_arbiter_2to1_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, arready, rvalid, rdata
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_arbiter_2to1
// Brief    : Two-master to one-slave AXI4-lite arbiter, one transaction at a time.
// Revision : 1.0
// ============================================================================
module axi_lite_arbiter_2to1 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIXED_PRIO = 0
) (
    input  wire logic                   CLK,
    input  wire logic                   RST,
    axi_lite_arbiter_2to1_if.slave      s0,
    axi_lite_arbiter_2to1_if.slave      s1,
    axi_lite_arbiter_2to1_if.master     m,
    output logic [1:0]                  grant
);
    localparam int       c_strb_width = DATA_WIDTH / 8;
    localparam bit [2:0] c_st_idle    = 3'd0;
    localparam bit [2:0] c_st_waddr   = 3'd1;
    localparam bit [2:0] c_st_wresp   = 3'd2;
    localparam bit [2:0] c_st_raddr   = 3'd3;
    localparam bit [2:0] c_st_rdata   = 3'd4;

    logic [2:0] r_state, w_state_next;
    logic [1:0] r_grant, w_grant_next;
    logic       r_rr_ptr, w_rr_next;
    logic       r_aw_done, w_aw_done_next;
    logic       r_w_done, w_w_done_next;

    logic w_wreq0, w_wreq1, w_req0, w_req1, w_pick1, w_win_wreq, w_sel;
    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

    logic                    w_m_awvalid, w_m_wvalid, w_m_bready, w_m_arvalid, w_m_rready;
    logic [ADDR_WIDTH-1:0]   w_m_awaddr, w_m_araddr;
    logic [2:0]              w_m_awprot, w_m_arprot;
    logic [DATA_WIDTH-1:0]   w_m_wdata, w_rdata;
    logic [c_strb_width-1:0] w_m_wstrb;
    logic                    w_awready, w_wready, w_bvalid, w_arready, w_rvalid;

    assign w_wreq0 = s0.awvalid | s0.wvalid;
    assign w_wreq1 = s1.awvalid | s1.wvalid;
    assign w_req0  = w_wreq0 | s0.arvalid;
    assign w_req1  = w_wreq1 | s1.arvalid;

    // rr_ptr = 1 means s1 is preferred on the next contention.
    assign w_pick1    = (w_req0 & w_req1) ? ((FIXED_PRIO != 0) ? 1'b0 : r_rr_ptr) : w_req1;
    assign w_win_wreq = w_pick1 ? w_wreq1 : w_wreq0;
    assign w_sel      = r_grant[1];

    assign w_aw_hs = w_m_awvalid & m.awready;
    assign w_w_hs  = w_m_wvalid  & m.wready;
    assign w_b_hs  = m.bvalid    & w_m_bready;
    assign w_ar_hs = w_m_arvalid & m.arready;
    assign w_r_hs  = m.rvalid    & w_m_rready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= c_st_idle;
            r_grant   <= 2'b00;
            r_rr_ptr  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_grant   <= w_grant_next;
            r_rr_ptr  <= w_rr_next;
            r_aw_done <= w_aw_done_next;
            r_w_done  <= w_w_done_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_grant_next   = r_grant;
        w_rr_next      = r_rr_ptr;
        w_aw_done_next = r_aw_done;
        w_w_done_next  = r_w_done;
        case (r_state)
            c_st_idle: begin
                if (w_req0 | w_req1) begin
                    w_grant_next = w_pick1 ? 2'b10 : 2'b01;
                    w_state_next = w_win_wreq ? c_st_waddr : c_st_raddr;
                end
            end
            c_st_waddr: begin
                w_aw_done_next = r_aw_done | w_aw_hs;
                w_w_done_next  = r_w_done  | w_w_hs;
                if (w_aw_done_next && w_w_done_next) begin
                    w_state_next = c_st_wresp;
                end
            end
            c_st_wresp: begin
                if (w_b_hs) begin
                    w_state_next   = c_st_idle;
                    w_grant_next   = 2'b00;
                    w_aw_done_next = 1'b0;
                    w_w_done_next  = 1'b0;
                    w_rr_next      = ~r_grant[1];
                end
            end
            c_st_raddr: begin
                if (w_ar_hs) begin
                    w_state_next = c_st_rdata;
                end
            end
            c_st_rdata: begin
                if (w_r_hs) begin
                    w_state_next = c_st_idle;
                    w_grant_next = 2'b00;
                    w_rr_next    = ~r_grant[1];
                end
            end
            default: begin
                w_state_next   = c_st_idle;
                w_grant_next   = 2'b00;
                w_aw_done_next = 1'b0;
                w_w_done_next  = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_m_awvalid = 1'b0;
        w_m_wvalid  = 1'b0;
        w_m_bready  = 1'b0;
        w_m_arvalid = 1'b0;
        w_m_rready  = 1'b0;
        w_awready   = 1'b0;
        w_wready    = 1'b0;
        w_bvalid    = 1'b0;
        w_arready   = 1'b0;
        w_rvalid    = 1'b0;
        w_rdata     = '0;
        w_m_awaddr  = '0;
        w_m_awprot  = '0;
        w_m_wdata   = '0;
        w_m_wstrb   = '0;
        w_m_araddr  = '0;
        w_m_arprot  = '0;
        if (r_grant != 2'b00) begin
            w_m_awaddr = w_sel ? s1.awaddr : s0.awaddr;
            w_m_awprot = w_sel ? s1.awprot : s0.awprot;
            w_m_wdata  = w_sel ? s1.wdata  : s0.wdata;
            w_m_wstrb  = w_sel ? s1.wstrb  : s0.wstrb;
            w_m_araddr = w_sel ? s1.araddr : s0.araddr;
            w_m_arprot = w_sel ? s1.arprot : s0.arprot;
        end
        case (r_state)
            c_st_waddr: begin
                // A completed channel stays quiet until the whole write retires.
                w_m_awvalid = (w_sel ? s1.awvalid : s0.awvalid) & ~r_aw_done;
                w_m_wvalid  = (w_sel ? s1.wvalid  : s0.wvalid)  & ~r_w_done;
                w_awready   = m.awready & ~r_aw_done;
                w_wready    = m.wready  & ~r_w_done;
            end
            c_st_wresp: begin
                w_bvalid   = m.bvalid;
                w_m_bready = w_sel ? s1.bready : s0.bready;
            end
            c_st_raddr: begin
                w_m_arvalid = w_sel ? s1.arvalid : s0.arvalid;
                w_arready   = m.arready;
            end
            c_st_rdata: begin
                w_rvalid   = m.rvalid;
                w_rdata    = m.rdata;
                w_m_rready = w_sel ? s1.rready : s0.rready;
            end
            default: begin
            end
        endcase
    end

    assign m.awvalid = w_m_awvalid;
    assign m.awaddr  = w_m_awaddr;
    assign m.awprot  = w_m_awprot;
    assign m.wvalid  = w_m_wvalid;
    assign m.wdata   = w_m_wdata;
    assign m.wstrb   = w_m_wstrb;
    assign m.bready  = w_m_bready;
    assign m.arvalid = w_m_arvalid;
    assign m.araddr  = w_m_araddr;
    assign m.arprot  = w_m_arprot;
    assign m.rready  = w_m_rready;

    assign s0.awready = w_awready & r_grant[0];
    assign s0.wready  = w_wready  & r_grant[0];
    assign s0.bvalid  = w_bvalid  & r_grant[0];
    assign s0.arready = w_arready & r_grant[0];
    assign s0.rvalid  = w_rvalid  & r_grant[0];
    assign s0.rdata   = r_grant[0] ? w_rdata : '0;
    assign s1.awready = w_awready & r_grant[1];
    assign s1.wready  = w_wready  & r_grant[1];
    assign s1.bvalid  = w_bvalid  & r_grant[1];
    assign s1.arready = w_arready & r_grant[1];
    assign s1.rvalid  = w_rvalid  & r_grant[1];
    assign s1.rdata   = r_grant[1] ? w_rdata : '0;

    assign grant = r_grant;
endmodule
`default_nettype wire
